// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode 7-segment scanner for a 16-bit hex word.
// New values are staged and committed only at the frame boundary.
module seg7_scan_driver #(
    parameter int DWELL_CYC = 10000,
    parameter int BLANK_CYC = 16,
    parameter int LZB       = 0
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    output logic        o_pending,
    output logic        o_frame,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp
);

    localparam int TMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] T_ON_LAST    = TW'(DWELL_CYC - 1);
    localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK_CYC - 1);

    typedef enum logic {
        S_BLANK,
        S_ON
    } state_t;

    state_t          state;
    logic [1:0]      idx;
    logic [TW-1:0]   timer;
    logic [15:0]     disp_reg;
    logic [15:0]     pend_reg;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every higher nibble are zero.
    function automatic logic [6:0] digit_seg(input logic [1:0] k,
                                             input logic [15:0] v);
        logic [15:0] hi;
        hi = v >> {k, 2'b00};
        if (LZB != 0 && k != 2'd0 && hi == 16'h0000)
            return 7'h7F;
        return hex_seg(hi[3:0]);
    endfunction

    assign o_dp = 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= S_BLANK;
            idx       <= 2'd0;
            timer     <= '0;
            disp_reg  <= 16'h0000;
            pend_reg  <= 16'h0000;
            o_pending <= 1'b0;
            o_frame   <= 1'b0;
            o_an      <= 4'b1111;
            o_seg     <= 7'h7F;
        end else begin
            o_frame <= 1'b0;
            if (i_valid) begin
                pend_reg  <= i_data;
                o_pending <= 1'b1;
            end
            case (state)
                S_BLANK: begin
                    if (timer == T_BLANK_LAST) begin
                        state <= S_ON;
                        timer <= '0;
                        o_an  <= ~(4'b0001 << idx);
                        o_seg <= digit_seg(idx, disp_reg);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (timer == T_ON_LAST) begin
                        state <= S_BLANK;
                        timer <= '0;
                        idx   <= idx + 2'd1;
                        o_an  <= 4'b1111;
                        o_seg <= 7'h7F;
                        if (idx == 2'd3) begin
                            o_frame <= 1'b1;
                            // A capture on this edge keeps the flag set for the new value.
                            if (o_pending) begin
                                disp_reg <= pend_reg;
                                if (!i_valid)
                                    o_pending <= 1'b0;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic
// against a frame-position reference model, with and without leading-zero blanking.
module tb_seg7_scan_driver;

    localparam int DW = 8;
    localparam int BL = 2;
    localparam int DC = DW + BL;
    localparam int FR = 4 * DC;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_data;

    logic        pend0, frame0, dp0;
    logic [3:0]  an0;
    logic [6:0]  seg0;
    logic        pend1, frame1, dp1;
    logic [3:0]  an1;
    logic [6:0]  seg1;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DWELL_CYC(DW), .BLANK_CYC(BL), .LZB(0)) dut0 (
        .clk_in(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_pending(pend0), .o_frame(frame0), .o_an(an0), .o_seg(seg0),
        .o_dp(dp0)
    );

    seg7_scan_driver #(.DWELL_CYC(DW), .BLANK_CYC(BL), .LZB(1)) dut1 (
        .clk_in(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_pending(pend1), .o_frame(frame1), .o_an(an1), .o_seg(seg1),
        .o_dp(dp1)
    );

    int compared = 0;
    int mismatched = 0;

    // Model: k = edges since reset; display/pending as the commit rules say.
    int          k;
    logic [15:0] m_disp, m_pval;
    logic        m_pflag;
    int          blank_run;
    logic [3:0]  prev_an;

    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int kk);
        if (kk % DC < BL) return 4'hF;
        return 4'(~(4'b0001 << ((kk / DC) % 4)));
    endfunction

    function automatic logic [6:0] exp_seg(input int kk, input logic [15:0] v,
                                           input bit lzb);
        int d;
        logic [15:0] hi;
        if (kk % DC < BL) return 7'h7F;
        d = (kk / DC) % 4;
        hi = v >> (4 * d);
        if (lzb && d > 0 && hi == 16'h0) return 7'h7F;
        return dec[int'(hi & 16'hF)];
    endfunction

    task automatic check_all();
        chk("an", 32'(an0), 32'(exp_an(k)));
        chk("an_lzb", 32'(an1), 32'(exp_an(k)));
        chk("seg", 32'(seg0), 32'(exp_seg(k, m_disp, 1'b0)));
        chk("seg_lzb", 32'(seg1), 32'(exp_seg(k, m_disp, 1'b1)));
        chk("dp", 32'({dp0, dp1}), 32'(2'b11));
        chk("pending", 32'({pend0, pend1}), 32'({m_pflag, m_pflag}));
        chk("frame", 32'({frame0, frame1}),
            32'({2{k != 0 && k % FR == 0}}));
        chk("an_onehot", 32'($countones(~an0)), 32'($countones(~an0) <= 1 ?
            $countones(~an0) : 1));
        if (an0 == 4'hF) begin
            blank_run = (k == 0) ? 1 : blank_run + 1;
        end else if (an0 != prev_an) begin
            chk("blank_gap", 32'(blank_run), 32'(BL));
            chk("gap_prev", 32'(prev_an), 32'(4'hF));
            blank_run = 0;
        end
        prev_an = an0;
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] d);
        rst = r;
        i_valid = v;
        i_data = d;
        @(posedge clk);
        if (r) begin
            k = 0;
            m_disp = 16'h0;
            m_pval = 16'h0;
            m_pflag = 1'b0;
        end else begin
            k++;
            if (k % FR == 0 && m_pflag) begin
                m_disp = m_pval;
                m_pflag = 1'b0;
            end
            if (v) begin
                m_pval = d;
                m_pflag = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic wait_to(input int target);
        int guard = 0;
        while (k % FR != target && guard < 2 * FR) begin
            step(1'b0, 1'b0, 16'h0);
            guard++;
        end
        chk("sync", 32'(k % FR), 32'(target));
    endtask

    initial begin
        k = 0;
        m_disp = 16'h0;
        m_pval = 16'h0;
        m_pflag = 1'b0;
        blank_run = 0;
        prev_an = 4'hF;
        rst = 1'b1;
        i_valid = 1'b0;
        i_data = 16'h0;

        // Reset, then one full idle frame of zeros.
        repeat (3) step(1'b1, 1'b0, 16'h0);
        chk("rst_an", 32'(an0), 32'(4'hF));
        chk("rst_seg", 32'(seg0), 32'(7'h7F));
        idle(2);
        chk("first_an", 32'(an0), 32'(4'hE));
        chk("first_seg", 32'(seg0), 32'(7'h40));
        idle(45);

        // Mid-frame capture of 1A3F.
        wait_to(15);
        step(1'b0, 1'b1, 16'h1A3F);
        chk("cap_pend", 32'(pend0), 32'(1'b1));
        idle(85);

        // Two captures in one frame: last write wins.
        wait_to(5);
        step(1'b0, 1'b1, 16'h1111);
        idle(4);
        step(1'b0, 1'b1, 16'h2222);
        idle(85);

        // Capture on the exact commit edge.
        wait_to(20);
        step(1'b0, 1'b1, 16'h4444);
        wait_to(FR - 1);
        step(1'b0, 1'b1, 16'h5555);
        chk("edge_pend", 32'(pend0), 32'(1'b1));
        idle(85);

        // Leading-zero blanking values.
        wait_to(10);
        step(1'b0, 1'b1, 16'h00B0);
        idle(80);
        step(1'b0, 1'b1, 16'h0000);
        idle(80);

        // Reset in the middle of digit 2 with a value pending.
        wait_to(10);
        step(1'b0, 1'b1, 16'h7777);
        wait_to(23);
        step(1'b1, 1'b0, 16'h0);
        chk("mid_rst_pend", 32'(pend0), 32'(1'b0));
        step(1'b1, 1'b0, 16'h0);
        idle(90);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 15) == 0),
                 16'($urandom));
        end
        idle(90);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
